// File: rtl/issue_select_arbiter.sv
// issue_select_arbiter
// Shares the single execute-issue slot between the Issue Queue (IQ) and the
// Load/Store Queue (LSQ). The winner is popped by a one-cycle combinational
// grant pulse and captured into a one-deep issue register that feeds execute
// through a valid/ready handshake. IQ wins contests by default; an aging
// counter forces the LSQ through after STARVE_LIMIT consecutive lost contests.
// Optional feature macro: ISS_ARB_RR_EN replaces fixed IQ priority with a
// 1-bit round-robin pointer (aging still overrides the pointer).
module issue_select_arbiter #(
    parameter int DATA_WIDTH   = 137,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FREEZE,
    input  logic                  FLUSH_IN,
    input  logic                  IQ_req_IN,
    input  logic [DATA_WIDTH-1:0] IQ_data_IN,
    output logic                  IQ_grant_OUT,
    input  logic                  LSQ_req_IN,
    input  logic [DATA_WIDTH-1:0] LSQ_data_IN,
    output logic                  LSQ_grant_OUT,
    input  logic                  EX_ready_IN,
    output logic                  ISS_valid_OUT,
    output logic [DATA_WIDTH-1:0] ISS_data_OUT,
    output logic                  ISS_mem_OUT
);

    // Issue register occupancy states
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] AGE_LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    logic [0:0]            iss_state_q, iss_state_d;
    logic [DATA_WIDTH-1:0] iss_data_q,  iss_data_d;
    logic                  iss_mem_q,   iss_mem_d;
    logic [CNT_WIDTH-1:0]  age_cnt_q,   age_cnt_d;

    logic slot;
    logic force_lsq;
    logic lsq_pick;
    logic iq_grant;
    logic lsq_grant;

`ifdef ISS_ARB_RR_EN
    logic rr_ptr_q, rr_ptr_d;
    logic contested;
`endif

    // Aging counter increment that sticks at the starvation limit
    function automatic logic [CNT_WIDTH-1:0] age_sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v >= AGE_LIMIT) begin
            return AGE_LIMIT;
        end
        return v + 1'b1;
    endfunction

    // Slot availability and winner selection; grants are pop pulses for this cycle
    always_comb begin
        slot = RESET && !FREEZE && !FLUSH_IN &&
               ((iss_state_q == ST_EMPTY) || EX_ready_IN);
        force_lsq = (age_cnt_q == AGE_LIMIT);
`ifdef ISS_ARB_RR_EN
        contested = IQ_req_IN && LSQ_req_IN;
        lsq_pick  = LSQ_req_IN && (!IQ_req_IN || force_lsq || rr_ptr_q);
`else
        lsq_pick  = LSQ_req_IN && (!IQ_req_IN || force_lsq);
`endif
        lsq_grant = slot && lsq_pick;
        iq_grant  = slot && IQ_req_IN && !lsq_pick;
    end

    // Next state of issue register, aging counter and round-robin pointer
    always_comb begin
        iss_state_d = iss_state_q;
        iss_data_d  = iss_data_q;
        iss_mem_d   = iss_mem_q;
        age_cnt_d   = age_cnt_q;
`ifdef ISS_ARB_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        if (!RESET) begin
            iss_state_d = ST_EMPTY;
            iss_data_d  = '0;
            iss_mem_d   = 1'b0;
            age_cnt_d   = '0;
`ifdef ISS_ARB_RR_EN
            rr_ptr_d    = 1'b0;
`endif
        end else if (FLUSH_IN) begin
            // Squash: drop the in-flight entry but keep its data bits
            iss_state_d = ST_EMPTY;
            iss_mem_d   = 1'b0;
            age_cnt_d   = '0;
        end else if (slot) begin
            if (iq_grant || lsq_grant) begin
                iss_state_d = ST_FULL;
                iss_data_d  = lsq_grant ? LSQ_data_IN : IQ_data_IN;
                iss_mem_d   = lsq_grant;
            end else if (iss_state_q == ST_FULL) begin
                // Execute took the entry and nothing refills it
                iss_state_d = ST_EMPTY;
            end

            if (lsq_grant || !LSQ_req_IN) begin
                age_cnt_d = '0;
            end else if (iq_grant) begin
                age_cnt_d = age_sat_inc(age_cnt_q);
            end

`ifdef ISS_ARB_RR_EN
            if (contested) begin
                rr_ptr_d = !rr_ptr_q;
            end
`endif
        end
    end

    // State registers; reset is folded into the _d logic above
    always_ff @(posedge CLK) begin
        iss_state_q <= iss_state_d;
        iss_data_q  <= iss_data_d;
        iss_mem_q   <= iss_mem_d;
        age_cnt_q   <= age_cnt_d;
`ifdef ISS_ARB_RR_EN
        rr_ptr_q    <= rr_ptr_d;
`endif
    end

    assign IQ_grant_OUT  = iq_grant;
    assign LSQ_grant_OUT = lsq_grant;
    assign ISS_valid_OUT = (iss_state_q == ST_FULL);
    assign ISS_data_OUT  = iss_data_q;
    assign ISS_mem_OUT   = iss_mem_q;

endmodule

// File: doc/issue_select_arbiter.md
# issue_select_arbiter

Issue-stage arbiter that shares the single execute-issue slot between the Issue Queue (IQ) and the Load/Store Queue (LSQ). Each cycle it grants at most one ready queue head, pops it via a one-cycle grant pulse, and registers the selected entry into a one-deep issue register that feeds execute under a valid/ready handshake. IQ has default priority. An LSQ aging counter bounds LSQ starvation.

## Interface
- DATA_WIDTH, 137: width of one IQ/LSQ entry.
- STARVE_LIMIT, 4: consecutive lost contests after which the LSQ is forced to win; legal range 1..(2^CNT_WIDTH - 1).
- CNT_WIDTH, 3: width of the aging counter.

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous reset, active-low.
- FREEZE  in  1  global stall; holds all state and suppresses grants.
- FLUSH_IN  in  1  squash; clears the issue register and the aging counter.
- IQ_req_IN  in  1  IQ head selected and ready.
- IQ_data_IN  in  DATA_WIDTH  IQ entry offered.
- IQ_grant_OUT  out  1  pop pulse to the IQ.
- LSQ_req_IN  in  1  LSQ head ready (source not busy).
- LSQ_data_IN  in  DATA_WIDTH  LSQ head entry.
- LSQ_grant_OUT  out  1  pop pulse to the LSQ.
- EX_ready_IN  in  1  execute accepts the issue register this cycle.
- ISS_valid_OUT  out  1  issue register holds an instruction.
- ISS_data_OUT  out  DATA_WIDTH  issued entry.
- ISS_mem_OUT  out  1  issued entry came from the LSQ.

## Operation
- Slot availability: slot = RESET && !FREEZE && !FLUSH_IN && (!ISS_valid_OUT || EX_ready_IN).
- Grants are combinational. At most one of IQ_grant_OUT and LSQ_grant_OUT is high. Both are 0 when slot = 0.
- Priority when both requests are high:
  - force = (age_cnt == STARVE_LIMIT).
  - LSQ wins if force is true; otherwise IQ wins.
  - A single requester always wins when slot = 1.
- Issue register update on a grant:
  - ISS_valid_OUT <= 1.
  - ISS_data_OUT <= the winner's data.
  - ISS_mem_OUT <= LSQ_grant_OUT.
- Issue register update with slot = 1 and no grant: if ISS_valid_OUT && EX_ready_IN, then ISS_valid_OUT <= 0 and the data is held.
- FREEZE with ISS_valid_OUT = 1: the issue register holds. EX_ready_IN is ignored.
- Aging counter (age_cnt), evaluated only when slot = 1:
  - Clears to 0 if the LSQ is granted or LSQ_req_IN = 0.
  - Increments, saturating at STARVE_LIMIT, if LSQ_req_IN = 1 and the IQ is granted.
  - Holds when slot = 0.
- FLUSH_IN (takes priority over everything except RESET):
  - ISS_valid_OUT <= 0, ISS_mem_OUT <= 0, age_cnt <= 0.
  - No grants that cycle. ISS_data_OUT holds.
- Issue register states: EMPTY (valid = 0) and FULL (valid = 1).
  - EMPTY to FULL on a grant.
  - FULL to FULL on EX_ready_IN plus a grant (back-to-back issue).
  - FULL to EMPTY on EX_ready_IN with no grant, or on flush.
  - FULL stays FULL on !EX_ready_IN or FREEZE.

## Timing
- Reset values: ISS_valid_OUT = 0, ISS_data_OUT = 0, ISS_mem_OUT = 0, age_cnt = 0. Grants read 0 while RESET = 0.
- Latency: request to ISS_valid_OUT is 1 cycle. Sustained throughput is 1 issue per cycle when EX_ready_IN = 1.
- Grant pulse is exactly the pop cycle. A queue must drop or advance its head on the next edge.
- Reset mid-operation discards the in-flight issue register contents. No grant is issued in the reset cycle.
- Simultaneous FLUSH_IN and EX_ready_IN: flush wins and nothing is consumed-then-refilled.

## Configuration
- ISS_ARB_RR_EN defined: a 1-bit round-robin pointer replaces fixed IQ priority. The pointer is reset to 0 (IQ first) and toggles only on a contested grant (both requests high). Aging still overrides the pointer.
- ISS_ARB_RR_EN undefined: fixed IQ priority plus aging, exactly as described in Operation.

## Test plan
- Reset: hold RESET = 0 for 2 cycles with both requests high -> no grants; ISS_valid_OUT = 0, ISS_data_OUT = 0.
- Single requester: IQ_req_IN = 1 with data 0xA5, EX_ready_IN = 1 -> IQ_grant_OUT = 1 at cycle 0; ISS_valid_OUT = 1, ISS_data_OUT = 0xA5, ISS_mem_OUT = 0 at cycle 1.
- Aging (macro off, STARVE_LIMIT = 4): both requests held high with EX_ready_IN = 1 -> IQ wins 4 cycles, LSQ wins the 5th with ISS_mem_OUT = 1, then IQ wins again.
- Backpressure: ISS_valid_OUT = 1, EX_ready_IN = 0 for 3 cycles with IQ_req_IN = 1 -> no grants; data stable; grant in the cycle EX_ready_IN rises.
- Flush/freeze: FULL register, assert FREEZE then FLUSH_IN -> FREEZE holds all state; FLUSH_IN gives ISS_valid_OUT = 0 next cycle, no grant that cycle, age_cnt = 0.
- RR (macro on): both requests high continuously -> grants alternate IQ, LSQ, IQ, LSQ starting with IQ.
